wb_pwm_multi: RTL and testbench

- Parametrised Wishbone-slave PWM generator. NCH channels share one prescaler and period counter; each channel has its own duty register.
- Period and duty writes are double-buffered (shadow → active) so that updates land glitch-free on a period boundary.
- Adds per-channel output inversion, counter readback and a period-wrap interrupt.
- Sits on the LM32 Wishbone bus, replacing fixed 8-channel motor PWM peripherals.

---
 rtl/wb_pwm_multi.sv | 111 +++++++++++
 tb/tb_wb_pwm_multi.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_pwm_multi.sv
// wb_pwm_multi: Wishbone-slave multi-channel PWM with double-buffered period/duty
// Ports: clk/rst (sync, active-high); wb_adr_i/wb_dat_i/wb_we_i/wb_cyc_i/wb_stb_i/wb_sel_i
// bus inputs; wb_dat_o registered read data; wb_ack_o acknowledge; pwm_o registered PWM
// outputs; irq_o one-cycle pulse on each period wrap when IRQ_EN is set.
module wb_pwm_multi #(
  parameter int NCH          = 8,
  parameter int CNT_W        = 16,
  parameter int wb_dat_width = 32,
  parameter int wb_adr_width = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [wb_adr_width-1:0] wb_adr_i,
  input  logic [wb_dat_width-1:0] wb_dat_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic [3:0]              wb_sel_i,
  output logic [wb_dat_width-1:0] wb_dat_o,
  output logic                    wb_ack_o,
  output logic [NCH-1:0]          pwm_o,
  output logic                    irq_o
);
  localparam int IW = NCH < 32 ? NCH : 32;
  logic ack_q, en_q, en_d, load_q, load_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic req, wr, tick, wrap, pend, xfer;
  logic [5:0] widx;
  logic [31:0] m, rd, dat_q, dat_d;
  logic [15:0] presc_q, presc_d, pre_q, pre_d;
  logic [CNT_W-1:0] period_s_q, period_s_d, period_a_q, period_a_d, cnt_q, cnt_d;
  logic [NCH-1:0] inv_q, inv_d, pwm_q, pwm_d;
  logic [CNT_W-1:0] duty_s_q [NCH];
  logic [CNT_W-1:0] duty_s_d [NCH];
  logic [CNT_W-1:0] duty_a_q [NCH];
  logic [CNT_W-1:0] duty_a_d [NCH];
  logic unused_ok;
  assign unused_ok = ^{wb_adr_i[wb_adr_width-1:8], wb_adr_i[1:0], wb_dat_i};
  always_comb begin
    req = wb_stb_i & wb_cyc_i & ~ack_q;
    wr = req & wb_we_i;
    widx = wb_adr_i[7:2];
    m = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    tick = en_q & (pre_q == presc_q);
    wrap = tick & (cnt_q == period_a_q);
    en_d = (wr && widx == 6'd0 && wb_sel_i[0]) ? wb_dat_i[0] : en_q;
    irq_en_d = (wr && widx == 6'd0 && wb_sel_i[0]) ? wb_dat_i[2] : irq_en_q;
    // a LOAD written on the wrap cycle itself is honoured on that wrap
    pend = load_q | (wr & (widx == 6'd0) & wb_sel_i[0] & wb_dat_i[1]);
    load_d = pend & ~wrap;
    xfer = ~en_q | (wrap & pend);
    period_s_d = (wr && widx == 6'd1) ? (period_s_q & ~m[CNT_W-1:0]) | (wb_dat_i[CNT_W-1:0] & m[CNT_W-1:0]) : period_s_q;
    presc_d = (wr && widx == 6'd2) ? (presc_q & ~m[15:0]) | (wb_dat_i[15:0] & m[15:0]) : presc_q;
    inv_d = inv_q;
    if (wr && widx == 6'd3) inv_d[IW-1:0] = (inv_q[IW-1:0] & ~m[IW-1:0]) | (wb_dat_i[IW-1:0] & m[IW-1:0]);
    period_a_d = xfer ? period_s_d : period_a_q;
    pre_d = (~en_q | tick) ? '0 : pre_q + 16'd1;
    cnt_d = (~en_q | wrap) ? '0 : cnt_q + CNT_W'(tick);
    irq_d = wrap & irq_en_q;
    rd = widx == 6'd0 ? {29'd0, irq_en_q, load_q, en_q} :
         widx == 6'd1 ? 32'(period_s_q) :
         widx == 6'd2 ? 32'(presc_q) :
         widx == 6'd3 ? 32'(inv_q[IW-1:0]) :
         widx == 6'd4 ? 32'(cnt_q) : '0;
    for (int i = 0; i < NCH; i++) begin
      duty_s_d[i] = (wr && widx == 6'(8 + i)) ? (duty_s_q[i] & ~m[CNT_W-1:0]) | (wb_dat_i[CNT_W-1:0] & m[CNT_W-1:0]) : duty_s_q[i];
      duty_a_d[i] = xfer ? duty_s_d[i] : duty_a_q[i];
      pwm_d[i] = (en_q & (cnt_q < duty_a_q[i])) ^ inv_q[i];
      if (widx == 6'(8 + i)) rd = 32'(duty_s_q[i]);
    end
    dat_d = req ? rd : dat_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      en_q <= 1'b0;
      load_q <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q <= 1'b0;
      dat_q <= '0;
      presc_q <= '0;
      pre_q <= '0;
      period_s_q <= '0;
      period_a_q <= '0;
      cnt_q <= '0;
      inv_q <= '0;
      pwm_q <= '0;
      duty_s_q <= '{default: '0};
      duty_a_q <= '{default: '0};
    end else begin
      ack_q <= req;
      en_q <= en_d;
      load_q <= load_d;
      irq_en_q <= irq_en_d;
      irq_q <= irq_d;
      dat_q <= dat_d;
      presc_q <= presc_d;
      pre_q <= pre_d;
      period_s_q <= period_s_d;
      period_a_q <= period_a_d;
      cnt_q <= cnt_d;
      inv_q <= inv_d;
      pwm_q <= pwm_d;
      duty_s_q <= duty_s_d;
      duty_a_q <= duty_a_d;
    end
  end
  assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_q;
  assign wb_dat_o = dat_q;
  assign pwm_o = pwm_q;
  assign irq_o = irq_q;
endmodule

// File: tb/tb_wb_pwm_multi.sv
// tb_wb_pwm_multi: scoreboard bench for wb_pwm_multi against a behavioural model
module tb_wb_pwm_multi;
  localparam int NCH = 8;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic wb_we_i = 1'b0;
  logic wb_cyc_i = 1'b0;
  logic wb_stb_i = 1'b0;
  logic [3:0] wb_sel_i = '0;
  logic [31:0] wb_dat_o;
  logic wb_ack_o;
  logic [NCH-1:0] pwm_o;
  logic irq_o;
  always #5 clk = ~clk;
  wb_pwm_multi #(.NCH(NCH), .CNT_W(CW), .wb_dat_width(32), .wb_adr_width(32)) dut (
    .clk(clk), .rst(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_sel_i(wb_sel_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .pwm_o(pwm_o), .irq_o(irq_o)
  );
  int checks = 0;
  int passes = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // behavioural model: register file, tick/period positions as modular counts
  bit m_en, m_load, m_irqen, m_ack, exp_irq, mon_on;
  logic [15:0] m_per_s, m_per_a, m_psc;
  logic [7:0] m_inv, exp_pwm;
  logic [15:0] m_ds [NCH];
  logic [15:0] m_da [NCH];
  int m_pre, m_cnt;
  logic [31:0] rdq [$];
  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction
  function automatic logic [31:0] regval(input int a);
    if (a == 0) return {29'd0, m_irqen, m_load, m_en};
    if (a == 4) return 32'(m_per_s);
    if (a == 8) return 32'(m_psc);
    if (a == 12) return 32'(m_inv);
    if (a == 16) return 32'(m_cnt);
    if (a >= 32 && a < 32 + 4 * NCH) return 32'(m_ds[(a - 32) / 4]);
    return 32'd0;
  endfunction
  always @(posedge clk) begin : model
    bit req, tick, wrap, ldq, nen;
    int a;
    if (rst) begin
      m_en = 0; m_load = 0; m_irqen = 0; m_ack = 0; m_per_s = 0; m_per_a = 0; m_psc = 0;
      m_inv = 0; m_pre = 0; m_cnt = 0; exp_pwm = 0; exp_irq = 0; rdq.delete();
      for (int i = 0; i < NCH; i++) begin m_ds[i] = 0; m_da[i] = 0; end
    end else begin
      a = int'(wb_adr_i[7:0]);
      req = wb_stb_i && wb_cyc_i && !m_ack;
      tick = m_en && m_pre == int'(m_psc);
      wrap = tick && m_cnt == int'(m_per_a);
      for (int i = 0; i < NCH; i++) exp_pwm[i] = (m_en && m_cnt < int'(m_da[i])) ^ m_inv[i];
      exp_irq = wrap && m_irqen;
      if (req && !wb_we_i) rdq.push_back(regval(a));
      ldq = m_load;
      nen = m_en;
      if (req && wb_we_i) begin
        if (a == 0) begin
          if (wb_sel_i[0]) begin nen = wb_dat_i[0]; m_irqen = wb_dat_i[2]; if (wb_dat_i[1]) ldq = 1; end
        end else if (a == 4) m_per_s = 16'(lanes(32'(m_per_s), wb_dat_i, wb_sel_i));
        else if (a == 8) m_psc = 16'(lanes(32'(m_psc), wb_dat_i, wb_sel_i));
        else if (a == 12) m_inv = 8'(lanes(32'(m_inv), wb_dat_i, wb_sel_i));
        else if (a >= 32 && a < 32 + 4 * NCH) m_ds[(a - 32) / 4] = 16'(lanes(32'(m_ds[(a - 32) / 4]), wb_dat_i, wb_sel_i));
      end
      if (m_en) begin
        m_pre = (m_pre + 1) % (int'(m_psc) + 1);
        if (tick) m_cnt = (m_cnt + 1) % (int'(m_per_a) + 1);
      end else begin
        m_pre = 0; m_cnt = 0;
      end
      if (!m_en || (wrap && ldq)) begin
        m_per_a = m_per_s;
        for (int i = 0; i < NCH; i++) m_da[i] = m_ds[i];
      end
      if (wrap) ldq = 0;
      m_load = ldq;
      m_en = nen;
      m_ack = req;
    end
  end
  always @(negedge clk) begin : monitor
    if (mon_on) begin
      chk("pwm", 64'(pwm_o), 64'(exp_pwm));
      chk("irq", 64'(irq_o), 64'(exp_irq));
      chk("ack", 64'(wb_ack_o), 64'(wb_stb_i && wb_cyc_i && m_ack));
      if (wb_ack_o && !wb_we_i) begin
        chk("rd_pending", 64'(rdq.size() > 0), 64'd1);
        if (rdq.size() > 0) chk("rd_data", 64'(wb_dat_o), 64'(rdq.pop_front()));
      end
    end
  end
  task automatic bus(input logic we, input int a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
    int k = 0;
    @(posedge clk); #1;
    wb_adr_i = 32'(a); wb_dat_i = d; wb_we_i = we; wb_sel_i = s; wb_cyc_i = 1; wb_stb_i = 1;
    do begin @(negedge clk); k++; end while (!wb_ack_o && k < 20);
    chk("ack_lat", 64'(k), 64'd2);
    r = wb_dat_o;
    @(posedge clk); #1;
    wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
  endtask
  task automatic wr(input int a, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, a, d, 4'hF, r);
  endtask
  task automatic rd(input int a, output logic [31:0] r);
    bus(1'b0, a, 32'd0, 4'hF, r);
  endtask
  task automatic measure(output int c0, output int c1, output int c2, output int ci, input int n);
    c0 = 0; c1 = 0; c2 = 0; ci = 0;
    repeat (n) begin
      @(negedge clk);
      c0 += int'(pwm_o[0]); c1 += int'(pwm_o[1]); c2 += int'(pwm_o[2]); ci += int'(irq_o);
    end
  endtask
  initial begin
    logic [31:0] r;
    int c0, c1, c2, ci;
    bit tb_en;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    mon_on = 1;
    @(negedge clk);
    chk("rst_pwm", 64'(pwm_o), 64'd0);
    rd(0, r); chk("rst_ctrl", 64'(r), 64'd0);
    rd(4, r); chk("rst_period", 64'(r), 64'd0);
    rd(16, r); chk("rst_count", 64'(r), 64'd0);
    rd(32, r); chk("rst_duty0", 64'(r), 64'd0);
    wr(8, 0); wr(4, 9); wr(32, 3); wr(36, 0); wr(40, 12); wr(0, 1);
    repeat (15) @(posedge clk);
    measure(c0, c1, c2, ci, 10);
    chk("duty3", 64'(c0), 64'd3); chk("duty0", 64'(c1), 64'd0);
    chk("duty_over", 64'(c2), 64'd10); chk("irq_off", 64'(ci), 64'd0);
    wr(32, 7);
    repeat (20) @(posedge clk);
    measure(c0, c1, c2, ci, 10);
    chk("no_load", 64'(c0), 64'd3);
    wr(0, 3);
    repeat (25) @(posedge clk);
    rd(0, r); chk("load_clr", 64'(r[1]), 64'd0);
    measure(c0, c1, c2, ci, 10);
    chk("duty7", 64'(c0), 64'd7);
    wr(0, 0); wr(8, 3); wr(4, 4); wr(0, 5);
    repeat (10) @(posedge clk);
    measure(c0, c1, c2, ci, 40);
    chk("irq_rate", 64'(ci), 64'd2);
    for (int i = 0; i < 6; i++) rd(16, r);
    wr(0, 0); wr(12, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("inv_pwm0", 64'(pwm_o[0]), 64'd1);
    bus(1'b1, 4, 32'hAABBCCDD, 4'b0001, r);
    rd(4, r); chk("sel_period", 64'(r), 64'hDD);
    wr(12, 0); wr(8, 0); wr(4, 200); wr(0, 1); wr(32, 50); wr(0, 3);
    repeat (30) @(posedge clk);
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_mid_pwm", 64'(pwm_o), 64'd0);
    rd(0, r); chk("rst_mid_ctrl", 64'(r), 64'd0);
    rd(4, r); chk("rst_mid_period", 64'(r), 64'd0);
    rd(32, r); chk("rst_mid_duty", 64'(r), 64'd0);
    repeat (20) @(posedge clk);
    tb_en = 0;
    for (int t = 0; t < 200; t++) begin
      int op = int'($urandom_range(0, 9));
      case (op)
        0: begin
          logic [31:0] d = 32'($urandom_range(0, 7));
          tb_en = d[0];
          wr(0, d);
        end
        1: if (!tb_en) wr(8, 32'($urandom_range(0, 2)));
        2: bus(1'b1, 4, 32'($urandom_range(0, 12)), 4'($urandom_range(1, 15)), r);
        3, 4: wr(32 + 4 * int'($urandom_range(0, NCH - 1)), 32'($urandom_range(0, 14)));
        5: wr(12, 32'($urandom_range(0, 255)));
        6: wr(16, $urandom());
        default: rd(4 * int'($urandom_range(0, 63)), r);
      endcase
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end
    repeat (10) @(posedge clk);
    chk("rdq_drained", 64'(rdq.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
